lsu_stbuf_queue: RTL and testbench

// - Committed-store FIFO directly upstream of the DCCM/PIC port controller. Accepts

---
 rtl/lsu_stbuf_queue_pkg.sv | 25 ++
 rtl/lsu_stbuf_queue_fwd_merge.sv | 32 +++
 rtl/lsu_stbuf_queue.sv | 156 +++++++++++++++
 tb/tb_lsu_stbuf_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stbuf_queue_pkg.sv
// Shared sizing, entry layout and address-compare helper for the LSU committed-store buffer.
package lsu_stbuf_queue_pkg;

  localparam int STBUF_DEPTH = 4;
  localparam int DCCM_BITS   = 16;
  localparam int DATA_W      = 32;
  localparam int BYTE_W      = DATA_W / 8;
  localparam int STBUF_PTR_W = $clog2(STBUF_DEPTH);
  // Every buffer entry plus the store being enqueued this cycle.
  localparam int FWD_SLOTS   = STBUF_DEPTH + 1;

  typedef struct packed {
    logic                   valid;
    logic                   in_pic;
    logic [DCCM_BITS-1:2]   addr;
    logic [DATA_W-1:0]      data;
    logic [BYTE_W-1:0]      byteen;
  } stbuf_entry_t;

  function automatic logic word_match(input logic [DCCM_BITS-1:2] entry_addr,
                                      input logic [DCCM_BITS-1:0] byte_addr);
    return entry_addr == byte_addr[DCCM_BITS-1:2];
  endfunction

endpackage

// File: rtl/lsu_stbuf_queue_fwd_merge.sv
// Age-priority byte merge for one load word: slots are ordered oldest (0) to youngest,
// so the youngest hitting slot with its byte enable set supplies each byte.
module lsu_stbuf_queue_fwd_merge
  import lsu_stbuf_queue_pkg::*;
(
  input  logic [FWD_SLOTS-1:0] slot_hit,
  input  logic [BYTE_W-1:0]    slot_byteen [FWD_SLOTS],
  input  logic [DATA_W-1:0]    slot_data   [FWD_SLOTS],
  output logic [DATA_W-1:0]    fwd_data,
  output logic [BYTE_W-1:0]    fwd_byteen
);

  logic [DATA_W-1:0] data_s;
  logic [BYTE_W-1:0] byteen_s;

  // Walk slots oldest to youngest; later hits overwrite earlier ones.
  always_comb begin
    data_s   = {DATA_W{1'b0}};
    byteen_s = {BYTE_W{1'b0}};
    for (int k = 0; k < FWD_SLOTS; k++) begin
      for (int b = 0; b < BYTE_W; b++) begin
        data_s[8*b +: 8] = (slot_hit[k] & slot_byteen[k][b]) ? slot_data[k][8*b +: 8]
                                                              : data_s[8*b +: 8];
        byteen_s[b]      = (slot_hit[k] & slot_byteen[k][b]) | byteen_s[b];
      end
    end
  end

  assign fwd_data   = data_s;
  assign fwd_byteen = byteen_s;

endmodule

// File: rtl/lsu_stbuf_queue.sv
// Committed-store FIFO ahead of the DCCM/PIC port: drains its head when committed and
// forwards pending store bytes to DC2 loads with a registered DC3 result.
module lsu_stbuf_queue
  import lsu_stbuf_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 lsu_freeze_dc3,
  input  logic                 stbuf_wr_en,
  input  logic [DCCM_BITS-1:0] stbuf_wr_addr,
  input  logic [DATA_W-1:0]    stbuf_wr_data,
  input  logic [BYTE_W-1:0]    stbuf_wr_byteen,
  input  logic                 stbuf_wr_in_pic,
  input  logic                 lsu_stbuf_commit_any,
  input  logic                 ld_vld_dc2,
  input  logic [DCCM_BITS-1:0] ld_addr_lo_dc2,
  input  logic [DCCM_BITS-1:0] ld_addr_hi_dc2,
  output logic                 stbuf_reqvld_any,
  output logic [DCCM_BITS-1:0] stbuf_addr_any,
  output logic [DATA_W-1:0]    stbuf_data_any,
  output logic                 stbuf_addr_in_pic_any,
  output logic                 stbuf_full_any,
  output logic                 stbuf_empty_any,
  output logic [DATA_W-1:0]    stbuf_fwddata_lo_dc3,
  output logic [DATA_W-1:0]    stbuf_fwddata_hi_dc3,
  output logic [BYTE_W-1:0]    stbuf_fwdbyteen_lo_dc3,
  output logic [BYTE_W-1:0]    stbuf_fwdbyteen_hi_dc3
);

  localparam logic [STBUF_PTR_W-1:0] PTR_ONE   = {{(STBUF_PTR_W-1){1'b0}}, 1'b1};
  localparam logic [STBUF_PTR_W:0]   CNT_DEPTH = (STBUF_PTR_W+1)'(STBUF_DEPTH);

  stbuf_entry_t               entry_r [STBUF_DEPTH];
  stbuf_entry_t               wr_entry_s;
  logic [STBUF_PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [STBUF_PTR_W:0]       count_r, count_nxt_s;
  logic                       full_r, empty_r;
  logic                       enq_s, deq_s, head_vld_s;

  logic [FWD_SLOTS-1:0]       hit_lo_s, hit_hi_s;
  logic [BYTE_W-1:0]          slot_byteen_s [FWD_SLOTS];
  logic [DATA_W-1:0]          slot_data_s   [FWD_SLOTS];
  logic [DATA_W-1:0]          merge_data_lo_s, merge_data_hi_s;
  logic [BYTE_W-1:0]          merge_byteen_lo_s, merge_byteen_hi_s;
  logic [DATA_W-1:0]          fwddata_lo_r, fwddata_hi_r;
  logic [BYTE_W-1:0]          fwdbyteen_lo_r, fwdbyteen_hi_r;
  logic                       unused_addr_lsb_s;

  assign head_vld_s  = entry_r[rd_ptr_r].valid;
  // Full is registered, so a same-cycle pop never frees room for a push.
  assign enq_s       = stbuf_wr_en & ~full_r & ~lsu_freeze_dc3;
  assign deq_s       = lsu_stbuf_commit_any & head_vld_s;
  assign count_nxt_s = count_r + (STBUF_PTR_W+1)'(enq_s) - (STBUF_PTR_W+1)'(deq_s);

  assign wr_entry_s = '{valid:  1'b1,
                        in_pic: stbuf_wr_in_pic,
                        addr:   stbuf_wr_addr[DCCM_BITS-1:2],
                        data:   stbuf_wr_data,
                        byteen: stbuf_wr_byteen};

  // Entry storage: write at wr_ptr on enqueue, invalidate head on dequeue.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < STBUF_DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STBUF_DEPTH; i++) begin
        if (enq_s && (wr_ptr_r == STBUF_PTR_W'(i))) begin
          entry_r[i] <= wr_entry_s;
        end else if (deq_s && (rd_ptr_r == STBUF_PTR_W'(i))) begin
          entry_r[i].valid <= 1'b0;
        end
      end
    end
  end

  // Pointers, occupancy count and the registered full/empty flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r <= {STBUF_PTR_W{1'b0}};
      rd_ptr_r <= {STBUF_PTR_W{1'b0}};
      count_r  <= {(STBUF_PTR_W+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= enq_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_r <= deq_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CNT_DEPTH);
      empty_r  <= (count_nxt_s == {(STBUF_PTR_W+1){1'b0}});
    end
  end

  // Slot k holds entry wr_ptr+k, so slot order is age order; the last slot is the incoming store.
  always_comb begin
    for (int k = 0; k < STBUF_DEPTH; k++) begin
      hit_lo_s[k]      = entry_r[wr_ptr_r + STBUF_PTR_W'(k)].valid &
                         word_match(entry_r[wr_ptr_r + STBUF_PTR_W'(k)].addr, ld_addr_lo_dc2);
      hit_hi_s[k]      = entry_r[wr_ptr_r + STBUF_PTR_W'(k)].valid &
                         word_match(entry_r[wr_ptr_r + STBUF_PTR_W'(k)].addr, ld_addr_hi_dc2);
      slot_byteen_s[k] = entry_r[wr_ptr_r + STBUF_PTR_W'(k)].byteen;
      slot_data_s[k]   = entry_r[wr_ptr_r + STBUF_PTR_W'(k)].data;
    end
    hit_lo_s[STBUF_DEPTH]      = enq_s & word_match(wr_entry_s.addr, ld_addr_lo_dc2);
    hit_hi_s[STBUF_DEPTH]      = enq_s & word_match(wr_entry_s.addr, ld_addr_hi_dc2);
    slot_byteen_s[STBUF_DEPTH] = wr_entry_s.byteen;
    slot_data_s[STBUF_DEPTH]   = wr_entry_s.data;
  end

  lsu_stbuf_queue_fwd_merge u_merge_lo (
    .slot_hit    (hit_lo_s),
    .slot_byteen (slot_byteen_s),
    .slot_data   (slot_data_s),
    .fwd_data    (merge_data_lo_s),
    .fwd_byteen  (merge_byteen_lo_s)
  );

  lsu_stbuf_queue_fwd_merge u_merge_hi (
    .slot_hit    (hit_hi_s),
    .slot_byteen (slot_byteen_s),
    .slot_data   (slot_data_s),
    .fwd_data    (merge_data_hi_s),
    .fwd_byteen  (merge_byteen_hi_s)
  );

  // DC3 forwarding flops: hold under freeze, clear when no load is in DC2.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fwddata_lo_r   <= {DATA_W{1'b0}};
      fwddata_hi_r   <= {DATA_W{1'b0}};
      fwdbyteen_lo_r <= {BYTE_W{1'b0}};
      fwdbyteen_hi_r <= {BYTE_W{1'b0}};
    end else if (!lsu_freeze_dc3) begin
      fwddata_lo_r   <= ld_vld_dc2 ? merge_data_lo_s   : {DATA_W{1'b0}};
      fwddata_hi_r   <= ld_vld_dc2 ? merge_data_hi_s   : {DATA_W{1'b0}};
      fwdbyteen_lo_r <= ld_vld_dc2 ? merge_byteen_lo_s : {BYTE_W{1'b0}};
      fwdbyteen_hi_r <= ld_vld_dc2 ? merge_byteen_hi_s : {BYTE_W{1'b0}};
    end
  end

  assign stbuf_reqvld_any       = head_vld_s;
  assign stbuf_addr_any         = {entry_r[rd_ptr_r].addr, 2'b00};
  assign stbuf_data_any         = entry_r[rd_ptr_r].data;
  assign stbuf_addr_in_pic_any  = entry_r[rd_ptr_r].in_pic;
  assign stbuf_full_any         = full_r;
  assign stbuf_empty_any        = empty_r;
  assign stbuf_fwddata_lo_dc3   = fwddata_lo_r;
  assign stbuf_fwddata_hi_dc3   = fwddata_hi_r;
  assign stbuf_fwdbyteen_lo_dc3 = fwdbyteen_lo_r;
  assign stbuf_fwdbyteen_hi_dc3 = fwdbyteen_hi_r;

  // Byte-offset bits play no part in word-granular storage or compare.
  assign unused_addr_lsb_s = ^{stbuf_wr_addr[1:0], ld_addr_lo_dc2[1:0], ld_addr_hi_dc2[1:0]};

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Self-checking bench for lsu_stbuf_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lsu_stbuf_queue;

  typedef struct {
    logic [13:0] w;
    logic [31:0] d;
    logic [3:0]  be;
    logic        pic;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        lsu_freeze_dc3, stbuf_wr_en, stbuf_wr_in_pic, lsu_stbuf_commit_any, ld_vld_dc2;
  logic [15:0] stbuf_wr_addr, ld_addr_lo_dc2, ld_addr_hi_dc2;
  logic [31:0] stbuf_wr_data;
  logic [3:0]  stbuf_wr_byteen;
  logic        stbuf_reqvld_any, stbuf_addr_in_pic_any, stbuf_full_any, stbuf_empty_any;
  logic [15:0] stbuf_addr_any;
  logic [31:0] stbuf_data_any, stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3;
  logic [3:0]  stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3;

  ent_t        q[$];
  logic [31:0] e_dlo, e_dhi;
  logic [3:0]  e_blo, e_bhi;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lsu_stbuf_queue dut (
    .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(lsu_freeze_dc3),
    .stbuf_wr_en(stbuf_wr_en), .stbuf_wr_addr(stbuf_wr_addr), .stbuf_wr_data(stbuf_wr_data),
    .stbuf_wr_byteen(stbuf_wr_byteen), .stbuf_wr_in_pic(stbuf_wr_in_pic),
    .lsu_stbuf_commit_any(lsu_stbuf_commit_any), .ld_vld_dc2(ld_vld_dc2),
    .ld_addr_lo_dc2(ld_addr_lo_dc2), .ld_addr_hi_dc2(ld_addr_hi_dc2),
    .stbuf_reqvld_any(stbuf_reqvld_any), .stbuf_addr_any(stbuf_addr_any),
    .stbuf_data_any(stbuf_data_any), .stbuf_addr_in_pic_any(stbuf_addr_in_pic_any),
    .stbuf_full_any(stbuf_full_any), .stbuf_empty_any(stbuf_empty_any),
    .stbuf_fwddata_lo_dc3(stbuf_fwddata_lo_dc3), .stbuf_fwddata_hi_dc3(stbuf_fwddata_hi_dc3),
    .stbuf_fwdbyteen_lo_dc3(stbuf_fwdbyteen_lo_dc3), .stbuf_fwdbyteen_hi_dc3(stbuf_fwdbyteen_hi_dc3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per byte, newest pending store to that word with the byte enabled wins.
  task automatic calc_word(input logic [13:0] w, input bit inc_v, input ent_t inc,
                           output logic [31:0] d, output logic [3:0] be);
    ent_t c[$];
    c = q;
    if (inc_v) c.push_back(inc);
    d = 32'h0;
    be = 4'h0;
    for (int b = 0; b < 4; b++) begin
      for (int i = c.size() - 1; i >= 0; i--) begin
        if (c[i].w == w && c[i].be[b]) begin
          d[8*b +: 8] = c[i].d[8*b +: 8];
          be[b] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("reqvld", {31'h0, stbuf_reqvld_any}, {31'h0, q.size() > 0});
    chk("full",   {31'h0, stbuf_full_any},   {31'h0, q.size() == 4});
    chk("empty",  {31'h0, stbuf_empty_any},  {31'h0, q.size() == 0});
    if (q.size() > 0) begin
      chk("head_addr", {16'h0, stbuf_addr_any}, {16'h0, q[0].w, 2'b00});
      chk("head_data", stbuf_data_any, q[0].d);
      chk("head_pic",  {31'h0, stbuf_addr_in_pic_any}, {31'h0, q[0].pic});
    end
    chk("fwddata_lo", stbuf_fwddata_lo_dc3, e_dlo);
    chk("fwddata_hi", stbuf_fwddata_hi_dc3, e_dhi);
    chk("fwdbe_lo", {28'h0, stbuf_fwdbyteen_lo_dc3}, {28'h0, e_blo});
    chk("fwdbe_hi", {28'h0, stbuf_fwdbyteen_hi_dc3}, {28'h0, e_bhi});
  endtask

  // Check current outputs, advance the model by one clock, then move to the next negedge.
  task automatic step();
    bit   enq, deq;
    ent_t inc;
    check_all();
    enq = stbuf_wr_en && (q.size() < 4) && !lsu_freeze_dc3;
    deq = lsu_stbuf_commit_any && (q.size() > 0);
    inc.w = stbuf_wr_addr[15:2];
    inc.d = stbuf_wr_data;
    inc.be = stbuf_wr_byteen;
    inc.pic = stbuf_wr_in_pic;
    if (!lsu_freeze_dc3) begin
      if (ld_vld_dc2) begin
        calc_word(ld_addr_lo_dc2[15:2], enq, inc, e_dlo, e_blo);
        calc_word(ld_addr_hi_dc2[15:2], enq, inc, e_dhi, e_bhi);
      end else begin
        e_dlo = 32'h0; e_dhi = 32'h0; e_blo = 4'h0; e_bhi = 4'h0;
      end
    end
    if (deq) void'(q.pop_front());
    if (enq) q.push_back(inc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    lsu_freeze_dc3 = 1'b0; stbuf_wr_en = 1'b0; stbuf_wr_in_pic = 1'b0;
    lsu_stbuf_commit_any = 1'b0; ld_vld_dc2 = 1'b0;
    stbuf_wr_addr = 16'h0; stbuf_wr_data = 32'h0; stbuf_wr_byteen = 4'h0;
    ld_addr_lo_dc2 = 16'h0; ld_addr_hi_dc2 = 16'h0;
  endtask

  task automatic model_reset();
    q.delete();
    e_dlo = 32'h0; e_dhi = 32'h0; e_blo = 4'h0; e_bhi = 4'h0;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    stbuf_wr_en = 1'b1; stbuf_wr_addr = a; stbuf_wr_data = d; stbuf_wr_byteen = be;
    step();
  endtask

  task automatic drain_all();
    idle();
    for (int i = 0; i < 6; i++) begin
      lsu_stbuf_commit_any = 1'b1;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reqvld", {31'h0, stbuf_reqvld_any}, 32'h0);
    chk("rst_empty",  {31'h0, stbuf_empty_any},  32'h1);
    chk("rst_full",   {31'h0, stbuf_full_any},   32'h0);
    chk("rst_fwd_lo", stbuf_fwddata_lo_dc3, 32'h0);
    rst_l = 1'b1;
    step();

    // Fill to four, then a fifth write must be dropped.
    for (int i = 0; i < 4; i++) push(16'h0040 + 16'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
    chk("fill_full", {31'h0, stbuf_full_any}, 32'h1);
    push(16'h0050, 32'hDEAD_BEEF, 4'hF);
    idle();
    for (int i = 0; i < 4; i++) begin
      lsu_stbuf_commit_any = 1'b1;
      step();
    end
    chk("fill_empty_after4", {31'h0, stbuf_empty_any}, 32'h1);
    idle();
    step();

    // Drain in order A0, A4, A8.
    push(16'h00A0, 32'hA0A0_A0A0, 4'hF);
    push(16'h00A4, 32'hA4A4_A4A4, 4'hF);
    push(16'h00A8, 32'hA8A8_A8A8, 4'hF);
    idle();
    lsu_stbuf_commit_any = 1'b1;
    chk("drain_a0", {16'h0, stbuf_addr_any}, 32'h00A0);
    step();
    chk("drain_a4", {16'h0, stbuf_addr_any}, 32'h00A4);
    step();
    chk("drain_a8", {16'h0, stbuf_addr_any}, 32'h00A8);
    step();
    chk("drain_empty", {31'h0, stbuf_empty_any}, 32'h1);
    idle();
    step();

    // Full with simultaneous write and commit: write dropped, head advances.
    for (int i = 0; i < 4; i++) push(16'h0060 + 16'(4 * i), 32'h6000_0000 + 32'(i), 4'hF);
    idle();
    stbuf_wr_en = 1'b1; stbuf_wr_addr = 16'h0070; stbuf_wr_data = 32'h7777_7777;
    stbuf_wr_byteen = 4'hF; lsu_stbuf_commit_any = 1'b1;
    step();
    idle();
    chk("fullsim_notfull", {31'h0, stbuf_full_any}, 32'h0);
    chk("fullsim_head", {16'h0, stbuf_addr_any}, 32'h0064);
    drain_all();

    // Youngest store wins per byte.
    push(16'h0010, 32'h1111_1111, 4'hF);
    push(16'h0010, 32'h0000_AA55, 4'h3);
    idle();
    ld_vld_dc2 = 1'b1; ld_addr_lo_dc2 = 16'h0010; ld_addr_hi_dc2 = 16'h0014;
    step();
    chk("fwd_young_data", stbuf_fwddata_lo_dc3, 32'h1111_AA55);
    chk("fwd_young_be", {28'h0, stbuf_fwdbyteen_lo_dc3}, 32'hF);

    // Freeze two cycles: fwd flops hold and writes are ignored.
    idle();
    lsu_freeze_dc3 = 1'b1; stbuf_wr_en = 1'b1; stbuf_wr_addr = 16'h0080;
    stbuf_wr_data = 32'h8888_8888; stbuf_wr_byteen = 4'hF;
    ld_vld_dc2 = 1'b1; ld_addr_lo_dc2 = 16'h0080;
    step();
    step();
    chk("freeze_hold", stbuf_fwddata_lo_dc3, 32'h1111_AA55);
    idle();
    chk("freeze_head", {16'h0, stbuf_addr_any}, 32'h0010);
    drain_all();

    // Unaligned load straddling two words.
    push(16'h0020, 32'h1200_0000, 4'h8);
    push(16'h0024, 32'h0000_0034, 4'h1);
    idle();
    ld_vld_dc2 = 1'b1; ld_addr_lo_dc2 = 16'h0023; ld_addr_hi_dc2 = 16'h0024;
    step();
    chk("unal_be_lo", {28'h0, stbuf_fwdbyteen_lo_dc3}, 32'h8);
    chk("unal_be_hi", {28'h0, stbuf_fwdbyteen_hi_dc3}, 32'h1);
    idle();
    step();

    // Reset in the middle of a drain.
    push(16'h0030, 32'h3030_3030, 4'hF);
    push(16'h0034, 32'h3434_3434, 4'hF);
    idle();
    lsu_stbuf_commit_any = 1'b1;
    step();
    #2 rst_l = 1'b0;
    #1;
    chk("midrst_reqvld", {31'h0, stbuf_reqvld_any}, 32'h0);
    chk("midrst_empty", {31'h0, stbuf_empty_any}, 32'h1);
    model_reset();
    idle();
    @(negedge clk);
    rst_l = 1'b1;
    step();

    // Randomized traffic over a small address window to provoke hits.
    for (int n = 0; n < 800; n++) begin
      lsu_freeze_dc3       = ($urandom_range(0, 9) == 0);
      stbuf_wr_en          = ($urandom_range(0, 9) < 6);
      stbuf_wr_addr        = 16'h0100 + 16'($urandom_range(0, 23));
      stbuf_wr_data        = $urandom;
      stbuf_wr_byteen      = 4'($urandom);
      stbuf_wr_in_pic      = 1'($urandom);
      lsu_stbuf_commit_any = ($urandom_range(0, 1) == 1);
      ld_vld_dc2           = ($urandom_range(0, 9) < 7);
      ld_addr_lo_dc2       = 16'h0100 + 16'($urandom_range(0, 23));
      ld_addr_hi_dc2       = ld_addr_lo_dc2 + 16'h0004;
      step();
    end
    idle();
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
